// File: rtl/cntr_pkg.sv
// Shared definitions for the counter family: mode selectors and the decoded
// count direction used by the up/down counter top.
package cntr_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  // Both or neither request asserted means no movement.
  function automatic dir_e decode_dir(input logic up, input logic down);
    if (up && !down)      return DIR_UP;
    else if (down && !up) return DIR_DOWN;
    else                  return DIR_HOLD;
  endfunction

endpackage

// File: rtl/t_ff.sv
// T flip-flop bit cell: toggles Q on a rising edge when T is high.
// RST_Q selects the value taken during asynchronous active-low reset.
module t_ff #(
  parameter logic RST_Q = 1'b0
) (
  input  logic rstn,
  input  logic clk,
  input  logic T,
  output logic Q,
  output logic Qn
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)  Q <= RST_Q;
    else if (T) Q <= ~Q;
  end

  assign Qn = ~Q;

endmodule

// File: rtl/updown_sync_cntr_param.sv
// Parametrised synchronous up/down counter built from T flip-flop cells, with
// modulus, wrap/saturate mode, sync clear/load, enable, carry/borrow and sticky ovf.
module updown_sync_cntr_param
  import cntr_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX     = (1 << WIDTH) - 1,
  parameter int MODE    = MODE_WRAP,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic             down,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             ovf,
  output logic [WIDTH-1:0] t_in
);

  if (WIDTH < 1) begin : g_bad_width
    $error("updown_sync_cntr_param: WIDTH must be >= 1");
  end
  if (MAX < 1 || MAX > (1 << WIDTH) - 1) begin : g_bad_max
    $error("updown_sync_cntr_param: MAX must be in 1..2**WIDTH-1");
  end
  if (RST_VAL < 0 || RST_VAL > MAX) begin : g_bad_rst
    $error("updown_sync_cntr_param: RST_VAL must be in 0..MAX");
  end
  if (MODE != MODE_WRAP && MODE != MODE_SAT) begin : g_bad_mode
    $error("updown_sync_cntr_param: MODE must be MODE_WRAP or MODE_SAT");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);
  localparam bit               SAT   = (MODE == MODE_SAT);

  dir_e             dir;
  logic             step;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_clamped;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff #(.RST_Q(RST_V[i])) u_t_ff (
      .rstn (rstn),
      .clk  (clk),
      .T    (t_in[i]),
      .Q    (count[i]),
      .Qn   (count_n[i])
    );
  end

  assign dir          = decode_dir(up, down);
  assign step         = en && !clr && !load;
  assign at_max       = (count == MAX_V);
  assign at_zero      = &count_n;
  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

  // NOTE: next_count gets a default before any branch, so no path through the
  // block leaves it unassigned and no latch is inferred.
  always_comb begin
    next_count = count;
    if (clr) begin
      next_count = '0;
    end else if (load) begin
      next_count = load_clamped;
    end else if (en) begin
      unique case (dir)
        DIR_UP:   next_count = at_max  ? (SAT ? count : '0)    : count + 1'b1;
        DIR_DOWN: next_count = at_zero ? (SAT ? count : MAX_V) : count - 1'b1;
        default:  next_count = count;
      endcase
    end
  end

  // The flops only see toggle requests, so the next state is encoded as a diff.
  assign t_in   = count ^ next_count;
  assign carry  = step && (dir == DIR_UP)   && at_max;
  assign borrow = step && (dir == DIR_DOWN) && at_zero;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                ovf <= 1'b0;
    else if (clr)             ovf <= 1'b0;
    else if (carry || borrow) ovf <= 1'b1;
  end

endmodule

// File: tb/tb_updown_sync_cntr_param.sv
// Directed self-checking bench: 4-bit mod-10 wrap and saturate counters plus an
// 8-bit full-range counter, all driven from one shared set of controls.
module tb_updown_sync_cntr_param;
  import cntr_pkg::*;

  logic       clk = 1'b0;
  logic       rstn, en, up, down, clr, load;
  logic [3:0] load_val4;
  logic [7:0] load_val8;

  logic [3:0] w_count, w_t_in, s_count, s_t_in;
  logic       w_carry, w_borrow, w_ovf, s_carry, s_borrow, s_ovf;
  logic [7:0] b_count, b_t_in;
  logic       b_carry, b_borrow, b_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  updown_sync_cntr_param #(.WIDTH(4), .MAX(9), .MODE(MODE_WRAP)) u_wrap (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .down(down), .clr(clr),
    .load(load), .load_val(load_val4), .count(w_count), .carry(w_carry),
    .borrow(w_borrow), .ovf(w_ovf), .t_in(w_t_in)
  );

  updown_sync_cntr_param #(.WIDTH(4), .MAX(9), .MODE(MODE_SAT)) u_sat (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .down(down), .clr(clr),
    .load(load), .load_val(load_val4), .count(s_count), .carry(s_carry),
    .borrow(s_borrow), .ovf(s_ovf), .t_in(s_t_in)
  );

  updown_sync_cntr_param #(.WIDTH(8)) u_w8 (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .down(down), .clr(clr),
    .load(load), .load_val(load_val8), .count(b_count), .carry(b_carry),
    .borrow(b_borrow), .ovf(b_ovf), .t_in(b_t_in)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; up = 1'b0; down = 1'b0; clr = 1'b0; load = 1'b0;
    load_val4 = '0; load_val8 = '0;
    #3;
    check("reset_count", w_count, 4'd0);
    check("reset_ovf", w_ovf, 1'b0);
    check("reset_w8_count", b_count, 8'd0);
    tick();
    rstn = 1'b1;

    // 1: async reset mid-count, then first count after release
    load = 1'b1; load_val4 = 4'd7;
    tick();
    load = 1'b0;
    check("t1_loaded7", w_count, 4'd7);
    #2 rstn = 1'b0;
    #1;
    check("t1_async_count", w_count, 4'd0);
    check("t1_async_ovf", w_ovf, 1'b0);
    rstn = 1'b1; en = 1'b1; up = 1'b1;
    tick();
    check("t1_first_up", w_count, 4'd1);

    // 2: count up across MAX=9
    load = 1'b1; load_val4 = 4'd8;
    tick();
    load = 1'b0;
    #1;
    check("t2_at8_count", w_count, 4'd8);
    check("t2_at8_carry", w_carry, 1'b0);
    tick();
    check("t2_at9_count", w_count, 4'd9);
    check("t2_at9_carry", w_carry, 1'b1);
    check("t2_at9_t_in", w_t_in, 4'b1001);
    check("t2_at9_ovf", w_ovf, 1'b0);
    tick();
    check("t2_wrap_count", w_count, 4'd0);
    check("t2_wrap_ovf", w_ovf, 1'b1);

    // 3: count down across 0
    clr = 1'b1; up = 1'b0;
    tick();
    check("t3_clr_ovf", w_ovf, 1'b0);
    clr = 1'b0; load = 1'b1; load_val4 = 4'd1;
    tick();
    load = 1'b0; down = 1'b1;
    #1;
    check("t3_at1_borrow", w_borrow, 1'b0);
    tick();
    check("t3_at0_count", w_count, 4'd0);
    check("t3_at0_borrow", w_borrow, 1'b1);
    check("t3_at0_t_in", w_t_in, 4'b1001);
    tick();
    check("t3_wrap_count", w_count, 4'd9);
    check("t3_wrap_ovf", w_ovf, 1'b1);

    // 4: saturate mode at both bounds
    down = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; load = 1'b1; load_val4 = 4'd9;
    tick();
    load = 1'b0; up = 1'b1;
    #1;
    check("t4_sat_ovf_pre", s_ovf, 1'b0);
    check("t4_sat_carry", s_carry, 1'b1);
    check("t4_sat_t_in", s_t_in, 4'd0);
    tick();
    check("t4_sat_hold9", s_count, 4'd9);
    check("t4_sat_ovf", s_ovf, 1'b1);
    clr = 1'b1;
    tick();
    check("t4_sat_clr_count", s_count, 4'd0);
    check("t4_sat_clr_ovf", s_ovf, 1'b0);
    clr = 1'b0; up = 1'b0; down = 1'b1;
    #1;
    check("t4_sat_borrow", s_borrow, 1'b1);
    check("t4_sat_t_in0", s_t_in, 4'd0);
    tick();
    check("t4_sat_hold0", s_count, 4'd0);
    check("t4_sat_ovf_dn", s_ovf, 1'b1);
    down = 1'b0;

    // 5: priority clr > load > count, and enable gating
    load = 1'b1; load_val4 = 4'd5;
    tick();
    check("t5_loaded5", w_count, 4'd5);
    clr = 1'b1; load = 1'b1; up = 1'b1; en = 1'b1; load_val4 = 4'd3;
    tick();
    check("t5_clr_wins", w_count, 4'd0);
    clr = 1'b0; up = 1'b0; load_val4 = 4'd12;
    tick();
    check("t5_load_clamp", w_count, 4'd9);
    load = 1'b0; en = 1'b0; up = 1'b1;
    #1;
    check("t5_en0_carry", w_carry, 1'b0);
    tick();
    check("t5_en0_hold", w_count, 4'd9);

    // 6: up and down together hold
    en = 1'b1; load = 1'b1; load_val4 = 4'd4;
    tick();
    load = 1'b0; up = 1'b1; down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t6_both_carry", w_carry, 1'b0);
      check("t6_both_borrow", w_borrow, 1'b0);
      check("t6_both_t_in", w_t_in, 4'd0);
      tick();
      check("t6_both_count", w_count, 4'd4);
    end

    // 6b: 8-bit default MAX wraps 255 -> 0
    down = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; load = 1'b1; load_val8 = 8'd255;
    tick();
    load = 1'b0;
    #1;
    check("t6_w8_at255", b_count, 8'd255);
    check("t6_w8_carry", b_carry, 1'b1);
    check("t6_w8_t_in", b_t_in, 8'hff);
    tick();
    check("t6_w8_wrap", b_count, 8'd0);
    check("t6_w8_ovf", b_ovf, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
